// File: rtl/sle_bank_driver_if.sv
// ---------------------------------------------------------------------------
// sle_bank_driver_if
// Command handshake between a sequencer and the SLE bank driver.
//
// Signals
//   cmd_valid  command present (master -> slave)
//   cmd_ready  driver accepts a command this cycle (slave -> master)
//   cmd_op     00 NOP, 01 LOAD, 10 CLEAR, 11 SHIFT
//   cmd_data   LOAD value; bit 0 is the SHIFT serial-in bit
//   cmd_count  SHIFT repeat count minus one
// ---------------------------------------------------------------------------
interface sle_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [3:0]       cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/sle_bank_driver.sv
// ---------------------------------------------------------------------------
// sle_bank_driver
// Drives the control and data pins of a bank of SLE flip-flops (D, EN, SLn,
// SD, LAT) from a simple command interface, and keeps a shadow copy of what
// the bank holds after its last enabled clock.
//
// Ports
//   i_clk     single clock, all state on the rising edge
//   i_rst     synchronous reset, active-high
//   cmd       command handshake (sle_bank_driver_if.slave)
//   o_d       bank D pins
//   o_en      bank clock enable
//   o_sln     bank synchronous load, active-low
//   o_sd      bank synchronous-load data, constant SD_VAL
//   o_lat     bank latch select, constant 0 (flip-flop mode)
//   o_shadow  expected bank content after the last EN cycle
//   o_done    one-cycle pulse on a command's final drive cycle
//   o_par     (only with SLE_BANK_DRIVER_PARITY_EN) registered even parity
//             of o_shadow
//
// Build option
//   SLE_BANK_DRIVER_PARITY_EN  adds o_par; absent in the default build.
//
// States
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a command, cmd_ready high, bank held (EN=0)
//   S_LOAD  | single drive cycle writing the latched value through D
//   S_CLEAR | single drive cycle pulsing SLn low so the bank takes SD_VAL
//   S_SHIFT | one or more drive cycles shifting the serial-in bit into D
// ---------------------------------------------------------------------------
module sle_bank_driver #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] SD_VAL = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sle_bank_driver_if.slave    cmd,
    output logic [WIDTH-1:0]    o_d,
    output logic                o_en,
    output logic                o_sln,
    output logic [WIDTH-1:0]    o_sd,
    output logic                o_lat,
    output logic [WIDTH-1:0]    o_shadow,
    output logic                o_done
`ifdef SLE_BANK_DRIVER_PARITY_EN
    ,
    output logic                o_par
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SHIFT = 2'b11;

    state_t           r_state;
    logic [WIDTH-1:0] r_d;
    logic             r_en;
    logic             r_sln;
    logic             r_done;
    logic [WIDTH-1:0] r_shadow;
    logic [3:0]       r_cnt;
    logic             r_sin;
    logic             w_accept;

    // Ready is held low during reset so nothing is accepted on the edge that
    // is clearing the block.
    assign cmd.cmd_ready = (r_state == S_IDLE) && !i_rst;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

    assign o_sd  = SD_VAL;
    assign o_lat = 1'b0;

    // Drive values are computed on the accepting edge so each first drive
    // cycle lands exactly one cycle after acceptance. The shadow is updated
    // on the edge that ends a drive cycle, i.e. the edge at which the bank
    // itself captures the driven value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_d      <= '0;
            r_en     <= 1'b0;
            r_sln    <= 1'b1;
            r_done   <= 1'b0;
            r_shadow <= '0;
            r_cnt    <= 4'd0;
            r_sin    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_en   <= 1'b0;
                    r_sln  <= 1'b1;
                    r_done <= 1'b0;
                    r_d    <= r_shadow;
                    if (w_accept) begin
                        case (cmd.cmd_op)
                            OP_LOAD: begin
                                r_state <= S_LOAD;
                                r_en    <= 1'b1;
                                r_d     <= cmd.cmd_data;
                                r_done  <= 1'b1;
                            end
                            OP_CLEAR: begin
                                r_state <= S_CLEAR;
                                r_en    <= 1'b1;
                                r_sln   <= 1'b0;
                                r_d     <= r_shadow;
                                r_done  <= 1'b1;
                            end
                            OP_SHIFT: begin
                                r_state <= S_SHIFT;
                                r_en    <= 1'b1;
                                r_sin   <= cmd.cmd_data[0];
                                r_d     <= {r_shadow[WIDTH-2:0], cmd.cmd_data[0]};
                                r_cnt   <= cmd.cmd_count;
                                r_done  <= (cmd.cmd_count == 4'd0);
                            end
                            default: begin
                                // NOP: accepted and dropped.
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end

                S_LOAD: begin
                    r_shadow <= r_d;
                    r_en     <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                S_CLEAR: begin
                    r_shadow <= SD_VAL;
                    r_d      <= SD_VAL;
                    r_en     <= 1'b0;
                    r_sln    <= 1'b1;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                S_SHIFT: begin
                    r_shadow <= r_d;
                    if (r_cnt == 4'd0) begin
                        r_en    <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Counter stops at zero; it never wraps.
                        r_d    <= {r_d[WIDTH-2:0], r_sin};
                        r_cnt  <= r_cnt - 4'd1;
                        r_done <= (r_cnt == 4'd1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_sln   <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_d      = r_d;
    assign o_en     = r_en;
    assign o_sln    = r_sln;
    assign o_done   = r_done;
    assign o_shadow = r_shadow;

`ifdef SLE_BANK_DRIVER_PARITY_EN
    logic r_par;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ^r_shadow;
        end
    end

    assign o_par = r_par;
`endif

endmodule

// File: tb/tb_sle_bank_driver.sv
// ---------------------------------------------------------------------------
// tb_sle_bank_driver
// Directed and randomized commands against a behavioural model of the bank
// contents; checks every drive and idle cycle.
// ---------------------------------------------------------------------------
module tb_sle_bank_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] o_d;
    logic       o_en;
    logic       o_sln;
    logic [7:0] o_sd;
    logic       o_lat;
    logic [7:0] o_shadow;
    logic       o_done;
`ifdef SLE_BANK_DRIVER_PARITY_EN
    logic       o_par;
`endif

    sle_bank_driver_if #(.WIDTH(8)) cmd_if ();

    sle_bank_driver #(.WIDTH(8), .SD_VAL(8'h00)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .cmd      (cmd_if),
        .o_d      (o_d),
        .o_en     (o_en),
        .o_sln    (o_sln),
        .o_sd     (o_sd),
        .o_lat    (o_lat),
        .o_shadow (o_shadow),
        .o_done   (o_done)
`ifdef SLE_BANK_DRIVER_PARITY_EN
        ,
        .o_par    (o_par)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_shadow = 8'h00;  // model bank content after last EN edge
    logic [7:0] m_vis    = 8'h00;  // model shadow visible in the current cycle
    logic       par_exp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge. Parity lags the
    // shadow by one cycle, so its expectation is the parity of what was
    // visible in the cycle that just ended.
    task automatic tick();
        par_exp = ^m_vis;
        @(posedge clk);
        #1;
        m_vis = m_shadow;
    endtask

    task automatic chk_par(input string tag);
`ifdef SLE_BANK_DRIVER_PARITY_EN
        chk(tag, o_par, par_exp);
`else
        n_vec = n_vec + 0;
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_en"},     o_en,            0);
        chk({tag, "_sln"},    o_sln,           1);
        chk({tag, "_done"},   o_done,          0);
        chk({tag, "_d"},      o_d,             m_shadow);
        chk({tag, "_shadow"}, o_shadow,        m_shadow);
        chk({tag, "_ready"},  cmd_if.cmd_ready, 1);
        chk_par({tag, "_par"});
    endtask

    task automatic scramble();
        cmd_if.cmd_op    = 2'($urandom);
        cmd_if.cmd_data  = 8'($urandom);
        cmd_if.cmd_count = 4'($urandom);
    endtask

    // Issue one command in the current (idle) cycle, check each drive cycle,
    // and return in the idle cycle that follows. With hold set, cmd_valid
    // stays high with junk fields while the driver is busy.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           input logic [3:0] cnt, input bit hold);
        int         n;
        logic [7:0] exp_d;
        logic       exp_sln;
        chk("ready_pre", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_count = cnt;
        tick();
        cmd_if.cmd_valid = hold;
        scramble();
        case (op)
            2'b01:   n = 1;
            2'b10:   n = 1;
            2'b11:   n = int'(cnt) + 1;
            default: n = 0;
        endcase
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b01:   begin exp_d = data;                          exp_sln = 1'b1; end
                2'b10:   begin exp_d = m_shadow;                      exp_sln = 1'b0; end
                default: begin exp_d = {m_shadow[6:0], data[0]};      exp_sln = 1'b1; end
            endcase
            chk("drv_en",     o_en,             1);
            chk("drv_sln",    o_sln,            exp_sln);
            chk("drv_d",      o_d,              exp_d);
            chk("drv_done",   o_done,           (i == n - 1));
            chk("drv_ready",  cmd_if.cmd_ready, 0);
            chk("drv_shadow", o_shadow,         m_shadow);
            chk_par("drv_par");
            m_shadow = (op == 2'b10) ? 8'h00 : exp_d;
            scramble();
            tick();
        end
        chk_idle("post");
    endtask

    task automatic idle_gap(input int k);
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            scramble();
            tick();
            chk_idle("gap");
        end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 8'h00;
        cmd_if.cmd_count = 4'h0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        par_exp = 1'b0;
        chk("rst_en",     o_en,             0);
        chk("rst_sln",    o_sln,            1);
        chk("rst_d",      o_d,              0);
        chk("rst_shadow", o_shadow,         0);
        chk("rst_done",   o_done,           0);
        chk("rst_ready",  cmd_if.cmd_ready, 0);
        chk("rst_sd",     o_sd,             8'h00);
        chk("rst_lat",    o_lat,            0);
        chk_par("rst_par");
        rst = 1'b0;
        tick();
        chk_idle("rel");

        // Directed scenarios
        run_cmd(2'b01, 8'hA5, 4'h0, 1'b0);
        run_cmd(2'b01, 8'h81, 4'h0, 1'b0);
        run_cmd(2'b11, 8'h01, 4'h2, 1'b0);
        chk("shift3_shadow", o_shadow, 8'h0F);
        run_cmd(2'b01, 8'hFF, 4'h0, 1'b0);
        run_cmd(2'b10, 8'h5A, 4'h7, 1'b0);
        chk("clear_shadow", o_shadow, 8'h00);
        run_cmd(2'b01, 8'h11, 4'h0, 1'b1);
        run_cmd(2'b01, 8'h22, 4'h0, 1'b1);
        run_cmd(2'b00, 8'h33, 4'h5, 1'b1);
        run_cmd(2'b01, 8'h07, 4'h0, 1'b0);
        idle_gap(1);
        run_cmd(2'b01, 8'h03, 4'h0, 1'b0);
        idle_gap(1);
        run_cmd(2'b11, 8'h00, 4'hF, 1'b0);

        // Reset asserted during the 5th drive cycle of a 16-long shift
        run_cmd(2'b01, 8'h3C, 4'h0, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b11;
        cmd_if.cmd_data  = 8'h01;
        cmd_if.cmd_count = 4'hF;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("ab_en",   o_en,   1);
            chk("ab_d",    o_d,    {m_shadow[6:0], 1'b1});
            chk("ab_done", o_done, 0);
            m_shadow = {m_shadow[6:0], 1'b1};
            if (i < 4) tick();
        end
        rst = 1'b1;
        m_shadow = 8'h00;
        tick();
        par_exp = 1'b0;
        chk("ab_rst_en",     o_en,             0);
        chk("ab_rst_done",   o_done,           0);
        chk("ab_rst_shadow", o_shadow,         0);
        chk("ab_rst_d",      o_d,              0);
        chk("ab_rst_ready",  cmd_if.cmd_ready, 0);
        chk_par("ab_rst_par");
        rst = 1'b0;
        tick();
        chk_idle("ab_rel");

        // Randomized command stream
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 4) idle_gap(int'($urandom_range(1, 3)));
            run_cmd(2'($urandom), 8'($urandom), 4'($urandom), bit'($urandom_range(0, 1)));
        end
        idle_gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
